instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Fetch/decode/control end of the program-counter interface for the primitive programmable device.
- Consumes the current PC and reads the instruction word from a synchronous instruction memory.
- Decodes the word into register-file/ALU control, and returns PCOp and the 8-bit jump offset to the program counter.
- Adds a multi-cycle FETCH/DECODE/EXEC sequence, an input-wait handshake for switch-source instructions, and a HALT state.

Parameters:
- INSTR_W, 32, instruction word width; decode fields are fixed to a 32-bit layout.
- ADDR_W, 8, PC and instruction-memory address width.

Ports:
- CLK  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- PC  in  ADDR_W  current program counter value
- pc_step  out  1  one-cycle strobe; PC updates (PC+1 or PC+offset) on the next rising edge
- PCOp  out  1  0 = increment by 1, 1 = add jump offset
- jmp_offset  out  8  instr[12:5], two's-complement offset to the PC
- imem_addr  out  ADDR_W  instruction memory address
- imem_rdata  in  INSTR_W  instruction memory data; valid one cycle after imem_addr is presented
- alu_flag  in  1  ALU comparison result for the current instruction
- in_valid  in  1  external switch input is valid
- in_ready  out  1  sequencer accepts the switch input this cycle
- rf_we  out  1  register-file write enable
- ws  out  2  write source: 0 const, 1 switches, 2 ALU, 3 reserved
- alu_op  out  5  instr[27:23]
- ra1  out  5  instr[22:18]
- ra2  out  5  instr[17:13]
- wa  out  5  instr[4:0]
- const_val  out  INSTR_W  instr[27:5] sign-extended to INSTR_W
- halted  out  1  sequencer is in HALT

Behaviour:
- Instruction fields:
  - [31] B, unconditional jump.
  - [30] C, conditional jump.
  - [29:28] WS.
  - [27:23] ALUop; [22:18] RA1; [17:13] RA2; [12:5] offset/const low bits; [4:0] WA.
- Reset (async, any state): state=FETCH, instruction register=0, every output 0 (imem_addr = PC combinationally, so it follows PC).
- imem_addr = PC at all times.
- FETCH: one cycle, memory read in flight -> DECODE.
- DECODE: instruction register <= imem_rdata. Next state:
  - HALT if B=1 and offset=0 (jump to self).
  - Else WAIT_IN if B=0, C=0, WS=1.
  - Else EXEC.
- EXEC: one cycle, decoded outputs driven from the instruction register.
  - pc_step=1.
  - PCOp = B | (C & alu_flag).
  - rf_we = ~B & ~C & (WS != 3).
  - -> FETCH.
- WAIT_IN:
  - in_ready=1, all other strobes 0.
  - When in_valid=1: rf_we=1, pc_step=1, PCOp=0 in the same cycle -> FETCH.
  - Stays in WAIT_IN indefinitely while in_valid=0.
- HALT: absorbing; pc_step=0, rf_we=0, halted=1; only rst exits.
- rf_we and pc_step are never asserted outside EXEC or the WAIT_IN accept cycle; at most one pc_step per instruction.
- Latency:
  - Non-wait instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Input instruction: 3 cycles + wait time.
- B and C both set: B dominates, PCOp=1 regardless of alu_flag.
- WS=3 with B=C=0: no register write, PC+1 (NOP).
- Offset wrap: the PC adds modulo 2^ADDR_W; the sequencer does no range check.
- in_valid asserted outside WAIT_IN: ignored, in_ready=0.
- rst asserted mid-EXEC: pc_step and rf_we drop immediately (async), and no PC update occurs that edge.

Optional Feature:
- Macro: INSTR_SEQUENCER_RETIRE_CNT_EN.
- Defined:
  - Extra output port retire_cnt (16 bits), reset 0.
  - Increments on every pc_step cycle and wraps 0xFFFF -> 0.
  - Freezes in HALT.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, PC=0, imem[0]=WS=0, const=5, WA=3 -> rf_we=1 with wa=3, const_val=5, PCOp=0, pc_step high exactly on cycle 3.
- imem word with C=1, offset=0xFC (-4), alu_flag=1 -> PCOp=1, jmp_offset=0xFC in EXEC; repeat with alu_flag=0 -> PCOp=0.
- WS=1 instruction, in_valid held 0 for 10 cycles then 1 -> in_ready high the whole time, pc_step/rf_we exactly once on the accept cycle, then FETCH.
- B=1, offset=0 -> halted=1 after DECODE, pc_step stays 0 for 20 cycles; rst -> halted=0, state FETCH.
- rst pulse during EXEC -> outputs 0 within the same cycle, sequence restarts from FETCH at the current PC.
- With INSTR_SEQUENCER_RETIRE_CNT_EN defined: 7 instructions then halt -> retire_cnt=7 and stays 7.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/control sequencer: reads the instruction at PC, decodes it, and returns PCOp/offset.
// Optional retire counter output is enabled by defining INSTR_SEQUENCER_RETIRE_CNT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | imem read of PC in flight
// DECODE   | latch imem_rdata into the instruction register, pick next
// EXEC     | drive decoded controls, pc_step/rf_we strobe for one cycle
// WAIT_IN  | switch-source write, hold in_ready until in_valid arrives
// HALT     | jump-to-self seen, absorbing until rst
module instr_sequencer #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 8
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  PC,
  output logic               pc_step,
  output logic               PCOp,
  output logic [7:0]         jmp_offset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               alu_flag,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               rf_we,
  output logic [1:0]         ws,
  output logic [4:0]         alu_op,
  output logic [4:0]         ra1,
  output logic [4:0]         ra2,
  output logic [4:0]         wa,
  output logic [INSTR_W-1:0] const_val,
  output logic               halted
`ifdef INSTR_SEQUENCER_RETIRE_CNT_EN
  ,
  output logic [15:0]        retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WAIT_IN = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t             state;
  logic [INSTR_W-1:0] ir;

  logic ir_b;
  logic ir_c;
  logic rd_b;
  logic rd_c;
  logic [1:0] rd_ws;
  logic [7:0] rd_off;

  assign ir_b   = ir[31];
  assign ir_c   = ir[30];
  assign rd_b   = imem_rdata[31];
  assign rd_c   = imem_rdata[30];
  assign rd_ws  = imem_rdata[29:28];
  assign rd_off = imem_rdata[12:5];

  assign imem_addr = PC;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      ir       <= '0;
      in_ready <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= imem_rdata;
          if (rd_b && (rd_off == 8'd0)) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!rd_b && !rd_c && (rd_ws == 2'd1)) begin
            state    <= S_WAIT_IN;
            in_ready <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: state <= S_FETCH;
        S_WAIT_IN: begin
          if (in_valid) begin
            state    <= S_FETCH;
            in_ready <= 1'b0;
          end
        end
        S_HALT: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
        default: begin
          state    <= S_FETCH;
          in_ready <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

  // Strobes depend on alu_flag/in_valid in the same cycle, so they are decoded
  // from the registered state rather than registered themselves.
  logic in_exec;
  logic in_accept;

  assign in_exec   = (state == S_EXEC);
  assign in_accept = (state == S_WAIT_IN) && in_valid;

  assign pc_step = in_exec || in_accept;
  assign PCOp    = in_exec && (ir_b || (ir_c && alu_flag));
  assign rf_we   = (in_exec && !ir_b && !ir_c && (ir[29:28] != 2'd3)) || in_accept;

  assign ws         = ir[29:28];
  assign alu_op     = ir[27:23];
  assign ra1        = ir[22:18];
  assign ra2        = ir[17:13];
  assign jmp_offset = ir[12:5];
  assign wa         = ir[4:0];
  assign const_val  = {{(INSTR_W-23){ir[27]}}, ir[27:5]};

`ifdef INSTR_SEQUENCER_RETIRE_CNT_EN
  // Counts every PC advance; naturally frozen in HALT since pc_step stays low there.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst)
      retire_cnt <= 16'd0;
    else if (pc_step)
      retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed + randomized bench for instr_sequencer; expectations come from a per-instruction model.
// Retire counter checks are included when INSTR_SEQUENCER_RETIRE_CNT_EN is defined.
module tb_instr_sequencer;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 8;

  logic               CLK = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  PC;
  logic               pc_step;
  logic               PCOp;
  logic [7:0]         jmp_offset;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               alu_flag;
  logic               in_valid;
  logic               in_ready;
  logic               rf_we;
  logic [1:0]         ws;
  logic [4:0]         alu_op;
  logic [4:0]         ra1;
  logic [4:0]         ra2;
  logic [4:0]         wa;
  logic [INSTR_W-1:0] const_val;
  logic               halted;
`ifdef INSTR_SEQUENCER_RETIRE_CNT_EN
  logic [15:0]        retire_cnt;
`endif

  logic [31:0] imem [256];
  int npass = 0;
  int ntotal = 0;
  int retired = 0;

  instr_sequencer #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .rst(rst), .PC(PC), .pc_step(pc_step), .PCOp(PCOp),
    .jmp_offset(jmp_offset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_flag(alu_flag), .in_valid(in_valid), .in_ready(in_ready), .rf_we(rf_we),
    .ws(ws), .alu_op(alu_op), .ra1(ra1), .ra2(ra2), .wa(wa),
    .const_val(const_val), .halted(halted)
`ifdef INSTR_SEQUENCER_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Synchronous instruction memory: data for the address seen at an edge is visible after it.
  always @(posedge CLK) imem_rdata <= imem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string ph);
    chk({ph, ".pc_step"}, 32'(pc_step), 32'(0));
    chk({ph, ".rf_we"}, 32'(rf_we), 32'(0));
    chk({ph, ".in_ready"}, 32'(in_ready), 32'(0));
    chk({ph, ".halted"}, 32'(halted), 32'(0));
    chk({ph, ".imem_addr"}, 32'(imem_addr), 32'(PC));
  endtask

  task automatic chk_retire(input string tag);
`ifdef INSTR_SEQUENCER_RETIRE_CNT_EN
    chk(tag, 32'(retire_cnt), 32'(retired[15:0]));
`else
    chk(tag, 32'(halted), 32'(halted === 1'b1));
`endif
  endtask

  // Runs one instruction from its FETCH cycle. Entered and left at posedge+1.
  // afl: 0/1 forces alu_flag in EXEC, 2 randomizes it.
  task automatic run_instr(input logic [31:0] w, input int afl, input int nwait, input bit rst_in_exec);
    logic b, c, af, pcop, we;
    logic [1:0] wsv;
    logic [7:0] off;
    b = w[31]; c = w[30]; wsv = w[29:28]; off = w[12:5];
    imem[PC] = w;
    in_valid = 1'($urandom_range(0, 1));
    alu_flag = 1'($urandom_range(0, 1));
    @(negedge CLK); chk_quiet("fetch");
    @(posedge CLK); #1;
    in_valid = 1'($urandom_range(0, 1));
    @(negedge CLK); chk_quiet("decode");
    @(posedge CLK); #1;
    if (b && off == 8'd0) begin
      for (int i = 0; i < 20; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        alu_flag = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("halt.halted", 32'(halted), 32'(1));
        chk("halt.pc_step", 32'(pc_step), 32'(0));
        chk("halt.rf_we", 32'(rf_we), 32'(0));
        chk("halt.in_ready", 32'(in_ready), 32'(0));
        chk_retire("halt.retire");
        @(posedge CLK); #1;
      end
      return;
    end
    if (!b && !c && wsv == 2'd1) begin
      in_valid = 1'b0;
      for (int i = 0; i < nwait; i++) begin
        alu_flag = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("wait.in_ready", 32'(in_ready), 32'(1));
        chk("wait.pc_step", 32'(pc_step), 32'(0));
        chk("wait.rf_we", 32'(rf_we), 32'(0));
        @(posedge CLK); #1;
      end
      in_valid = 1'b1;
      @(negedge CLK);
      chk("accept.in_ready", 32'(in_ready), 32'(1));
      chk("accept.pc_step", 32'(pc_step), 32'(1));
      chk("accept.rf_we", 32'(rf_we), 32'(1));
      chk("accept.PCOp", 32'(PCOp), 32'(0));
      chk("accept.wa", 32'(wa), 32'(w[4:0]));
      retired++;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      PC = PC + 8'd1;
      return;
    end
    af = (afl == 2) ? 1'($urandom_range(0, 1)) : 1'(afl);
    alu_flag = af;
    in_valid = 1'($urandom_range(0, 1));
    pcop = b | (c & af);
    we = !b && !c && (wsv != 2'd3);
    if (rst_in_exec) begin
      #2;
      chk("rstexec.pre_pc_step", 32'(pc_step), 32'(1));
      rst = 1'b1;
      #1;
      chk("rstexec.pc_step", 32'(pc_step), 32'(0));
      chk("rstexec.rf_we", 32'(rf_we), 32'(0));
      chk("rstexec.PCOp", 32'(PCOp), 32'(0));
      retired = 0;
      @(posedge CLK); #1;
      rst = 1'b0;
      return;
    end
    @(negedge CLK);
    chk("exec.pc_step", 32'(pc_step), 32'(1));
    chk("exec.PCOp", 32'(PCOp), 32'(pcop));
    chk("exec.rf_we", 32'(rf_we), 32'(we));
    chk("exec.jmp_offset", 32'(jmp_offset), 32'(off));
    chk("exec.ws", 32'(ws), 32'(wsv));
    chk("exec.alu_op", 32'(alu_op), 32'(w[27:23]));
    chk("exec.ra1", 32'(ra1), 32'(w[22:18]));
    chk("exec.ra2", 32'(ra2), 32'(w[17:13]));
    chk("exec.wa", 32'(wa), 32'(w[4:0]));
    chk("exec.const_val", const_val, {{9{w[27]}}, w[27:5]});
    chk("exec.in_ready", 32'(in_ready), 32'(0));
    retired++;
    @(posedge CLK); #1;
    PC = pcop ? PC + off : PC + 8'd1;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; PC = '0; in_valid = 1'b1; alu_flag = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst.pc_step", 32'(pc_step), 32'(0));
    chk("rst.PCOp", 32'(PCOp), 32'(0));
    chk("rst.rf_we", 32'(rf_we), 32'(0));
    chk("rst.in_ready", 32'(in_ready), 32'(0));
    chk("rst.halted", 32'(halted), 32'(0));
    chk("rst.wa", 32'(wa), 32'(0));
    chk("rst.const_val", const_val, 32'(0));
    chk("rst.jmp_offset", 32'(jmp_offset), 32'(0));
    chk_retire("rst.retire");
    @(posedge CLK); #1;
    rst = 1'b0;

    // const write: WS=0, const=5, WA=3
    run_instr({4'b0000, 23'd5, 5'd3}, 2, 0, 0);
    // conditional jump -4, taken then not taken
    run_instr({4'b0110, 5'd7, 5'd1, 5'd2, 8'hFC, 5'd9}, 1, 0, 0);
    chk("pc.after_taken", 32'(PC), 32'(8'hFD));
    run_instr({4'b0110, 5'd7, 5'd1, 5'd2, 8'hFC, 5'd9}, 0, 0, 0);
    chk("pc.after_not_taken", 32'(PC), 32'(8'hFE));
    // switch input with a 10-cycle wait
    run_instr({4'b0001, 15'd0, 8'd0, 5'd12}, 2, 10, 0);
    // B and C both set: B dominates
    run_instr({4'b1100, 15'd0, 8'h10, 5'd1}, 0, 0, 0);
    // WS=3 NOP
    run_instr({4'b0011, 5'd4, 5'd5, 5'd6, 8'h22, 5'd7}, 2, 0, 0);
    // backward jump with PC wrap
    PC = 8'h02;
    run_instr({4'b1000, 15'd0, 8'hF0, 5'd0}, 2, 0, 0);
    chk("pc.wrap", 32'(PC), 32'(8'hF2));

    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      if (w[31] && w[12:5] == 8'd0) w[5] = 1'b1;
      run_instr(w, 2, $urandom_range(0, 5), 0);
    end

    // reset during EXEC, then the same instruction reruns from the same PC
    w = {4'b0000, 23'h12345, 5'd17};
    run_instr(w, 2, 0, 1);
    run_instr(w, 2, 0, 0);
    for (int n = 0; n < 6; n++) begin
      w = $urandom;
      if (w[31] && w[12:5] == 8'd0) w[5] = 1'b1;
      run_instr(w, 2, $urandom_range(0, 3), 0);
    end
    chk_retire("retire.seven");

    run_instr({4'b1000, 15'd0, 8'd0, 5'd0}, 2, 0, 0);
    rst = 1'b1;
    #1;
    chk("halt_rst.halted", 32'(halted), 32'(0));
    chk("halt_rst.pc_step", 32'(pc_step), 32'(0));
    retired = 0;
    @(posedge CLK); #1;
    rst = 1'b0;
    PC = 8'h40;
    run_instr({4'b0000, 23'd9, 5'd2}, 2, 0, 0);
    chk("pc.after_halt_restart", 32'(PC), 32'(8'h41));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
